// File: rtl/inst_fetch_queue.sv
// Instruction fetch front-end: owns the fetch PC, keeps at most one word request
// outstanding and buffers returned {pc, word} pairs for the core in a small FIFO.
module inst_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        init,
  output logic        mem_req,
  output logic [31:0] mem_adr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_take,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] word;
  } entry_t;

  entry_t           fifo_mem [DEPTH];
  entry_t           new_entry;
  entry_t           head_d;
  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d, count_after_pop;
  logic             discard_q, discard_d;
  logic             pending_d;
  logic             mem_req_d;
  logic [31:0]      mem_adr_d;
  logic             inst_valid_d;
  logic             ack, push, pop;
  logic             unused_redirect_lo;

  // Target is word aligned; the low address bits carry no information.
  assign unused_redirect_lo = ^redirect_pc[1:0];

  assign new_entry = '{pc: fetch_pc_q, word: mem_data};

  // mem_req doubles as the pending flag: it stays high until its ack.
  always_comb begin
    ack             = mem_req & mem_ack;
    pop             = inst_valid & inst_take;
    push            = ack & ~discard_q & ~redirect;
    count_after_pop = count_q - CNT_W'(pop);
    pending_d       = mem_req & ~ack;
    discard_d       = discard_q & ~ack;
    fetch_pc_d      = fetch_pc_q;
    rd_ptr_d        = rd_ptr_q;
    wr_ptr_d        = wr_ptr_q;
    count_d         = count_q;
    mem_req_d       = 1'b0;
    mem_adr_d       = mem_adr;
    inst_valid_d    = 1'b0;
    head_d          = '0;

    if (redirect) begin
      // Flush; an unacked request in flight becomes stale and is dropped on return.
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      discard_d  = pending_d;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PTR_W'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_after_pop + CNT_W'(push);
    end

    mem_req_d = pending_d | (count_d < FULL);
    mem_adr_d = pending_d ? mem_adr : fetch_pc_d;

    // Head is registered; a push into an otherwise empty queue bypasses storage.
    inst_valid_d = (count_d != '0);
    if (inst_valid_d) begin
      head_d = (push && count_after_pop == '0) ? new_entry : fifo_mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!init) begin
      fetch_pc_q <= RESET_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      discard_q  <= 1'b0;
      mem_req    <= 1'b0;
      mem_adr    <= RESET_PC;
      inst_valid <= 1'b0;
      inst       <= '0;
      inst_pc    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      discard_q  <= discard_d;
      mem_req    <= mem_req_d;
      mem_adr    <= mem_adr_d;
      inst_valid <= inst_valid_d;
      inst       <= head_d.word;
      inst_pc    <= head_d.pc;
    end
  end

  // Storage array needs no reset; count and pointers qualify its contents.
  always_ff @(posedge clk) begin
    if (init && push) begin
      fifo_mem[wr_ptr_q] <= new_entry;
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios then random traffic, every cycle
// compared against a queue-based transaction model.
module tb_inst_fetch_queue;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        init = 1'b0;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_data = '0;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_take = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  always #5 clk = ~clk;

  inst_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk), .init(init),
    .mem_req(mem_req), .mem_adr(mem_adr), .mem_ack(mem_ack), .mem_data(mem_data),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .inst_take(inst_take), .redirect(redirect), .redirect_pc(redirect_pc)
  );

  int total = 0;
  int bad   = 0;

  // Reference: queue of {pc, word}, fetch address, one outstanding request.
  logic [63:0] m_q[$];
  logic [31:0] m_fetch_pc = RESET_PC;
  logic [31:0] m_adr = RESET_PC;
  bit          m_req = 1'b0;
  bit          m_stale = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_step(input logic i_init, input logic i_ack, input logic i_take,
                            input logic i_redir, input logic [31:0] i_rpc,
                            input logic [31:0] i_data);
    if (!i_init) begin
      m_q.delete();
      m_fetch_pc = RESET_PC;
      m_adr      = RESET_PC;
      m_req      = 1'b0;
      m_stale    = 1'b0;
      return;
    end
    if (i_take && m_q.size() != 0) void'(m_q.pop_front());
    if (i_redir) begin
      m_q.delete();
      m_fetch_pc = {i_rpc[31:2], 2'b00};
      if (m_req && !i_ack) m_stale = 1'b1;
      else begin
        m_req   = 1'b0;
        m_stale = 1'b0;
      end
    end else if (m_req && i_ack) begin
      if (!m_stale) begin
        m_q.push_back({m_fetch_pc, i_data});
        m_fetch_pc = m_fetch_pc + 32'd4;
      end
      m_stale = 1'b0;
      m_req   = 1'b0;
    end
    if (!m_req && m_q.size() < DEPTH) begin
      m_req = 1'b1;
      m_adr = m_fetch_pc;
    end
  endtask

  task automatic step(input logic i_init, input logic i_ack, input logic i_take,
                      input logic i_redir, input logic [31:0] i_rpc,
                      input logic [31:0] i_data);
    logic [63:0] head;
    init        = i_init;
    mem_ack     = i_ack;
    inst_take   = i_take;
    redirect    = i_redir;
    redirect_pc = i_rpc;
    mem_data    = i_data;
    model_step(i_init, i_ack, i_take, i_redir, i_rpc, i_data);
    @(posedge clk);
    #1;
    check("mem_req", 32'(mem_req), 32'(m_req));
    if (m_req || !i_init) check("mem_adr", mem_adr, m_adr);
    check("inst_valid", 32'(inst_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) begin
      head = m_q[0];
      check("inst_pc", inst_pc, head[63:32]);
      check("inst", inst, head[31:0]);
    end
  endtask

  // Zero-wait fetch: ack whenever the model expects a request; word = address.
  task automatic fetch(input logic take);
    step(1'b1, m_req, take, 1'b0, 32'h0, m_adr);
  endtask

  initial begin
    logic        r_init, r_ack, r_take, r_redir;
    logic [31:0] r_rpc, r_data;

    // Reset and sequential streaming with the core always taking.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 32'h40, 32'h0);
    check("rst_req", 32'(mem_req), 32'h0);
    check("rst_adr", mem_adr, RESET_PC);
    check("rst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_pc", inst_pc, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("first_req", 32'(mem_req), 32'h1);
    check("first_adr", mem_adr, RESET_PC);
    for (int i = 0; i < 8; i++) fetch(1'b1);
    check("seq_pc", inst_pc, 32'd28);

    // Core stalled: queue fills, request drops, one take re-arms.
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int i = 0; i < 6; i++) fetch(1'b0);
    check("full_req", 32'(mem_req), 32'h0);
    check("full_head", inst_pc, 32'h0);
    step(1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
    check("rearm_req", 32'(mem_req), 32'h1);
    check("rearm_adr", mem_adr, 32'd16);

    // Redirect with no request outstanding; low target bits ignored.
    fetch(1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_0103, 32'h0);
    check("redir_valid", 32'(inst_valid), 32'h0);
    check("redir_adr", mem_adr, 32'h100);
    fetch(1'b0);
    check("redir_pc", inst_pc, 32'h100);

    // Redirect while a request stalls: old address holds, stale word dropped.
    fetch(1'b0);
    check("stall_adr0", mem_adr, 32'h108);
    step(1'b1, 1'b0, 1'b0, 1'b1, 32'h200, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      check("stall_adr", mem_adr, 32'h108);
    end
    step(1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h108);
    check("stale_valid", 32'(inst_valid), 32'h0);
    check("stale_adr", mem_adr, 32'h200);
    fetch(1'b0);
    check("stale_pc", inst_pc, 32'h200);

    // Redirect, take and ack in the same cycle.
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 32'h204);
    check("tri_valid", 32'(inst_valid), 32'h0);
    check("tri_adr", mem_adr, 32'h300);
    fetch(1'b1);
    check("tri_pc", inst_pc, 32'h300);

    // Fetch PC wrap, then reset in the middle of a stall.
    step(1'b1, m_req, 1'b0, 1'b1, 32'hFFFF_FFFC, m_adr);
    check("wrap_adr0", mem_adr, 32'hFFFF_FFFC);
    fetch(1'b0);
    check("wrap_pc", inst_pc, 32'hFFFF_FFFC);
    check("wrap_adr", mem_adr, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("mid_rst_req", 32'(mem_req), 32'h0);
    check("mid_rst_valid", 32'(inst_valid), 32'h0);
    check("mid_rst_pc", inst_pc, 32'h0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    check("post_rst_adr", mem_adr, RESET_PC);

    // Random traffic: wait states, spurious acks, takes, redirects, resets.
    for (int i = 0; i < 3000; i++) begin
      r_init  = ($urandom_range(0, 199) != 0);
      r_ack   = m_req ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      r_take  = ($urandom_range(0, 9) < 6);
      r_redir = ($urandom_range(0, 19) == 0);
      r_rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                            : 32'($urandom);
      r_data  = 32'($urandom);
      step(r_init, r_ack, r_take, r_redir, r_rpc, r_data);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
